// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer and its combinational core.
// The optional accumulator is enabled with the ALU_SEQ_ACC_EN macro (see alu_seq_ctrl).
package alu_pkg;

    localparam int DATA_W   = 8;
    localparam int MUL_ITER = 8;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL1 = 3'b101,
        OP_SHR1 = 3'b110,
        OP_MUL  = 3'b111
    } alu_op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_DONE
    } state_e;

    function automatic logic [3:0] make_flags(input logic [DATA_W-1:0] y,
                                              input logic c,
                                              input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (y == '0);
        f[FLAG_C] = c;
        f[FLAG_N] = y[DATA_W-1];
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 8-bit ALU for the seven single-cycle ops; MUL is sequenced by the caller.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    logic [WIDTH:0] sum;
    logic           c;
    logic           v;

    // NOTE: every variable driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        sum = '0;
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra bit wraps to 1 exactly when a < b, which is the borrow.
                sum = {1'b0, a} - {1'b0, b};
                y   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL1: begin
                y = {a[WIDTH-2:0], 1'b0};
                c = a[WIDTH-1];
            end
            OP_SHR1: begin
                y = {1'b0, a[WIDTH-1:1]};
                c = a[0];
            end
            default: y = '0;
        endcase
        flags = make_flags(y, c, v);
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer: valid/ready command in, held valid/ready result out, 8-step shift-add MUL.
// Define ALU_SEQ_ACC_EN to add an accumulator selectable as operand A.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] res_hi,
    output logic [3:0]       res_flags,
    output logic             busy
);

    localparam int CNT_W = $clog2(MUL_ITER);

    state_e             state;
    alu_op_e            op_q;
    logic [2*WIDTH-1:0] a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   core_y;
    logic [3:0]         core_flags;

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] acc;
    assign a_sel = cmd_use_acc ? acc : cmd_a;
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign a_sel          = cmd_a;
`endif

    assign cmd_ready = ena && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign prod_next = b_q[0] ? prod + a_q : prod;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op    (op_q),
        .a     (a_q[WIDTH-1:0]),
        .b     (b_q),
        .y     (core_y),
        .flags (core_flags)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            prod      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_hi    <= '0;
            res_flags <= '0;
`ifdef ALU_SEQ_ACC_EN
            acc       <= '0;
`endif
        end else if (ena) begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= alu_op_e'(cmd_op);
                        a_q   <= {{WIDTH{1'b0}}, a_sel};
                        b_q   <= cmd_b;
                        cnt   <= '0;
                        prod  <= '0;
                        state <= (alu_op_e'(cmd_op) == OP_MUL) ? ST_MUL : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_data  <= core_y;
                    res_hi    <= '0;
                    res_flags <= core_flags;
                    res_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_MUL: begin
                    prod <= prod_next;
                    a_q  <= a_q << 1;
                    b_q  <= b_q >> 1;
                    cnt  <= cnt + 1'b1;
                    // Result registers are only written once the product is complete.
                    if (cnt == CNT_W'(MUL_ITER - 1)) begin
                        res_data  <= prod_next[WIDTH-1:0];
                        res_hi    <= prod_next[2*WIDTH-1:WIDTH];
                        res_flags <= make_flags(prod_next[WIDTH-1:0],
                                                |prod_next[2*WIDTH-1:WIDTH], 1'b0);
                        res_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
`ifdef ALU_SEQ_ACC_EN
                        acc       <= res_data;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: vector table plus hand-written reset/enable sequences.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_use_acc = 1'b0;
    logic       res_ready = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_a = 8'd0;
    logic [7:0] cmd_b = 8'd0;
    logic       cmd_ready;
    logic       res_valid;
    logic       busy;
    logic [7:0] res_data;
    logic [7:0] res_hi;
    logic [3:0] res_flags;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_hi      (res_hi),
        .res_flags   (res_flags),
        .busy        (busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] hi;
        logic [3:0] flags;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       rdy_early;
        int         hold;
        exp_t       exp;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic rdy_early, input int hold,
                                input logic [7:0] data, input logic [7:0] hi, input logic [3:0] flags);
        vec_t v;
        v.op        = op;
        v.a         = a;
        v.b         = b;
        v.rdy_early = rdy_early;
        v.hold      = hold;
        v.exp.data  = data;
        v.exp.hi    = hi;
        v.exp.flags = flags;
        return v;
    endfunction

    // Issues one command, checks latency and handshake behaviour, compares against the scoreboard.
    task automatic run_cmd(input string name, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic use_acc, input logic rdy_early,
                           input int hold, input exp_t exp);
        int   lat;
        bit   got;
        exp_t e;
        exp_t act;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        res_ready   = rdy_early;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (cmd_ready) got = 1'b1;
            else @(negedge clk);
        end
        check({name, " accept"}, 32'(got), 32'd1);
        if (!got) begin
            cmd_valid = 1'b0;
            return;
        end
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_op      = ~op;
        cmd_a       = ~a;
        cmd_b       = 8'($urandom);
        cmd_use_acc = ~use_acc;
        check({name, " busy"}, 32'(busy), 32'd1);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (res_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({name, " latency"}, 32'(lat), (op == 3'b111) ? 32'd8 : 32'd1);
        check({name, " cmd_ready in DONE"}, 32'(cmd_ready), 32'd0);
        act = {res_data, res_hi, res_flags};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, " hold stable"}, {11'd0, cmd_ready, res_valid, res_data, res_hi, res_flags},
                  {11'd0, 1'b0, 1'b1, act});
        end
        res_ready = 1'b1;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " res_data"}, 32'(res_data), 32'(e.data));
            check({name, " res_hi"}, 32'(res_hi), 32'(e.hi));
            check({name, " res_flags"}, 32'(res_flags), 32'(e.flags));
        end
        @(negedge clk);
        check({name, " res_valid dropped"}, 32'(res_valid), 32'd0);
        check({name, " cmd_ready back"}, 32'(cmd_ready), 32'd1);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        bit   got;
        exp_t x;

        // Flags are {V,N,C,Z}.
        vecs[0]  = mk(3'b000, 8'h7F, 8'h01, 1'b0, 0, 8'h80, 8'h00, 4'b1100);
        vecs[1]  = mk(3'b001, 8'h10, 8'h20, 1'b0, 5, 8'hF0, 8'h00, 4'b0110);
        vecs[2]  = mk(3'b000, 8'hFF, 8'h01, 1'b1, 0, 8'h00, 8'h00, 4'b0011);
        vecs[3]  = mk(3'b001, 8'h80, 8'h01, 1'b0, 0, 8'h7F, 8'h00, 4'b1000);
        vecs[4]  = mk(3'b010, 8'hF0, 8'h0F, 1'b1, 0, 8'h00, 8'h00, 4'b0001);
        vecs[5]  = mk(3'b011, 8'hA5, 8'h5A, 1'b0, 0, 8'hFF, 8'h00, 4'b0100);
        vecs[6]  = mk(3'b100, 8'hFF, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 4'b0001);
        vecs[7]  = mk(3'b101, 8'h81, 8'h00, 1'b1, 0, 8'h02, 8'h00, 4'b0010);
        vecs[8]  = mk(3'b110, 8'h81, 8'h00, 1'b0, 0, 8'h40, 8'h00, 4'b0010);
        vecs[9]  = mk(3'b111, 8'hFF, 8'hFF, 1'b0, 2, 8'h01, 8'hFE, 4'b0010);
        vecs[10] = mk(3'b111, 8'h00, 8'h37, 1'b1, 0, 8'h00, 8'h00, 4'b0001);
        vecs[11] = mk(3'b111, 8'h10, 8'h10, 1'b0, 0, 8'h00, 8'h01, 4'b0011);
        vecs[12] = mk(3'b111, 8'h0C, 8'h0B, 1'b1, 0, 8'h84, 8'h00, 4'b0100);
        vecs[13] = mk(3'b001, 8'h05, 8'h05, 1'b0, 0, 8'h00, 8'h00, 4'b0001);
        vecs[14] = mk(3'b000, 8'h40, 8'h40, 1'b0, 0, 8'h80, 8'h00, 4'b1100);

        ena = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset outputs", {11'd0, busy, res_valid, res_data, res_hi, res_flags}, 32'd0);

        foreach (vecs[i])
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0,
                    vecs[i].rdy_early, vecs[i].hold, vecs[i].exp);

        // Asynchronous reset while the multiplier is in its fourth iteration.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'b111;
        cmd_a     = 8'hFF;
        cmd_b     = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midmul reset outputs", {11'd0, busy, res_valid, res_data, res_hi, res_flags}, 32'd0);
        check("midmul reset cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd("and after reset", 3'b010, 8'hF0, 8'h0F, 1'b0, 1'b0, 0, {8'h00, 8'h00, 4'b0001});

        // Enable low freezes a MUL mid-flight and then a held result.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'b111;
        cmd_a     = 8'h0C;
        cmd_b     = 8'h0B;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        ena       = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ena low frozen", {29'd0, cmd_ready, res_valid, busy}, 32'd1);
        end
        cmd_valid = 1'b0;
        ena = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (res_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check("ena resume latency", 32'(lat), 32'd6);
        res_ready = 1'b1;
        ena       = 1'b0;
        @(negedge clk);
        x = {res_data, res_hi, res_flags};
        check("ena low holds result", {11'd0, res_valid, x}, {11'd0, 1'b1, 8'h84, 8'h00, 4'b0100});
        ena = 1'b1;
        @(negedge clk);
        check("ena resume consume", 32'(res_valid), 32'd0);
        res_ready = 1'b0;

`ifdef ALU_SEQ_ACC_EN
        run_cmd("acc add", 3'b000, 8'h05, 8'h03, 1'b0, 1'b0, 0, {8'h08, 8'h00, 4'b0000});
        run_cmd("acc shl1", 3'b101, 8'hAA, 8'h00, 1'b1, 1'b0, 0, {8'h10, 8'h00, 4'b0000});
`endif

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Command sequencer for the 8-bit ALU datapath inside `tt_um_mialu`. It accepts one operation at a time over a valid/ready command port and runs single-cycle ops in one cycle. MUL runs as an 8-iteration shift-add loop. The result, high byte and flags are held on a valid/ready result port until consumed. It sits between the pin-level input decoder and the `uo_out`/`uio_out` drivers.

## Interface
- `WIDTH`, 8: operand/result width; only 8 is supported.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design enable; low freezes all state, and `cmd_ready` is forced 0.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on a clk edge where `cmd_valid & cmd_ready`.
- `cmd_op`  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1 (logical), 111 MUL.
- `cmd_a`, `cmd_b`  in  8 each  operands.
- `cmd_use_acc`  in  1  replace A with the accumulator; ignored unless `ALU_SEQ_ACC_EN` is defined.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  8  result low byte.
- `res_hi`  out  8  MUL high byte; 0 for all other ops.
- `res_flags`  out  4  {V,N,C,Z}.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: `cmd_ready = ena`.
  - On accept:
    - MUL → MUL, iteration count = 0.
    - Any other op → EXEC.
  - EXEC: one cycle. Computes via `alu_core`, registers the result and flags, → DONE.
  - MUL:
    - Each cycle: if `b[0]`, add `a` into the 16-bit product; shift `a` left and `b` right.
    - After the 8th iteration → DONE.
  - DONE:
    - `res_valid = 1`; all outputs stable.
    - `res_ready` high → IDLE.
- Operands are latched at accept. Later changes on `cmd_*` have no effect.
- Flags:
  - Z = (`res_data` == 0).
  - N = `res_data[7]`.
  - C:
    - ADD: carry-out.
    - SUB: borrow (A < B unsigned).
    - SHL1: old bit 7. SHR1: old bit 0.
    - MUL: `res_hi` ≠ 0.
    - Logic ops: 0.
  - V: two's-complement overflow for ADD and SUB; 0 otherwise.
- Arithmetic is mod 256. MUL product is 16-bit unsigned: {`res_hi`,`res_data`}.
- Reset (async, any state, including mid-MUL):
  - State → IDLE.
  - `res_data`, `res_hi`, `res_flags`, `res_valid`, `busy` → 0.
  - Accumulator → 0.
  - No partial result is ever presented.
- `ena` low: state, counter and registers hold. Outputs keep their values, including `res_valid`.

## Timing
- ADD..SHR1: accept at edge k; `res_valid` at edge k+1.
- MUL: accept at edge k; `res_valid` at edge k+8.
- Result handshake completes at the first edge with `res_valid & res_ready`.
  - `cmd_ready` rises after that edge.
  - No command is accepted in the same cycle a result is consumed.
  - Minimum spacing: 3 cycles for simple ops, 10 cycles for MUL.
- `res_ready` held high in advance: the result still shows for exactly one cycle.

## Configuration
- `ALU_SEQ_ACC_EN` defined:
  - An 8-bit accumulator loads `res_data` at every DONE→IDLE transition.
  - An accepted command with `cmd_use_acc = 1` takes the accumulator as A. `cmd_a` is ignored.
- Undefined:
  - No accumulator register.
  - `cmd_use_acc` is a no-op.
  - A is always `cmd_a`.

## Structure
- Shared package `alu_pkg`:
  - Opcode enum.
  - Flag bit indices (Z=0, C=1, N=2, V=3).
  - State enum (IDLE, EXEC, MUL, DONE).
  - `MUL_ITER = 8`.
- Sub-module `alu_core`: purely combinational. Takes `op`, `a`, `b`; produces `y[7:0]` and flags for the seven non-MUL ops. Reused by the top-level datapath.
- The MUL loop and the FSM live in `alu_seq_ctrl`.

## Test plan
- Reset → `cmd_ready = 1` (with `ena = 1`), `res_valid = 0`, outputs 0.
- ADD 0x7F + 0x01 → edge +1: `res_data` 0x80, flags V=1, N=1, C=0, Z=0.
- SUB 0x10 − 0x20 → 0xF0, C=1, N=1, V=0. Hold `res_ready = 0` for 5 cycles → outputs stable; `cmd_ready` stays 0.
- MUL 0xFF × 0xFF → `res_valid` exactly 8 edges after accept; `res_hi` 0xFE, `res_data` 0x01, C=1.
- Reset asserted during MUL iteration 4 → immediate IDLE, outputs 0. A following AND 0xF0 & 0x0F → 0x00, Z=1.
- With `ALU_SEQ_ACC_EN`:
  - ADD 0x05 + 0x03 → 0x08.
  - Then SHL1 with `cmd_use_acc = 1`, `cmd_a` = 0xAA → 0x10, C=0.
  - Toggle `ena` low mid-sequence → state frozen, resumes unchanged.
